// File: rtl/ic_fill_ctrl.sv
`timescale 1ns/1ps
// Instruction-cache line fill controller: critical-word-first line request,
// reorders four 16-bit beats into a 64-bit line, then one-cycle tag/data commit.
module ic_fill_ctrl #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 8,
  parameter int WAY_W  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_valid,
  output logic                       miss_ready,
  input  logic [ADDR_W-1:0]          miss_addr,
  input  logic [WAY_W-1:0]           miss_way,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_W-1:0]          mem_req_addr,
  input  logic                       mem_rsp_valid,
  input  logic [15:0]                mem_rsp_data,
  input  logic                       mem_rsp_err,
  output logic                       wr_en,
  output logic [LINE_W-1:0]          wr_line,
  output logic [WAY_W-1:0]           wr_way,
  output logic [63:0]                wr_data,
  output logic                       tag_wr_en,
  output logic [ADDR_W-LINE_W-3:0]   tag_wr_tag,
  output logic                       tag_wr_valid,
  output logic                       crit_valid,
  output logic [15:0]                crit_data,
  output logic                       fill_err,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, REQ, RECV, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                crit_vld_q, crit_vld_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [3:0][15:0]    data_q;
  logic [15:0]         crit_data_q;
  logic                beat;
  logic [1:0]          slot;
  logic                commit;

  // Beat k lands in word (crit_word + k) mod 4; the 2-bit add wraps naturally.
  assign slot = addr_q[1:0] + cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    addr_d     = addr_q;
    way_d      = way_q;
    crit_vld_d = 1'b0;
    beat       = 1'b0;
    case (state_q)
      IDLE: if (miss_valid) begin
        addr_d  = miss_addr;
        way_d   = miss_way;
        cnt_d   = 2'd0;
        err_d   = 1'b0;
        state_d = REQ;
      end
      REQ: if (mem_req_ready) state_d = RECV;
      RECV: if (mem_rsp_valid) begin
        beat       = 1'b1;
        cnt_d      = cnt_q + 2'd1;
        err_d      = err_q | mem_rsp_err;
        crit_vld_d = (cnt_q == 2'd0) && !mem_rsp_err;
        if (cnt_q == 2'd3) state_d = COMMIT;
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      err_q      <= 1'b0;
      crit_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      crit_vld_q <= crit_vld_d;
    end
  end

  // Capture registers carry no reset; every output they feed is state-gated.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    way_q  <= way_d;
    if (beat) data_q[slot] <= mem_rsp_data;
    if (beat && cnt_q == 2'd0) crit_data_q <= mem_rsp_data;
  end

  assign commit        = (state_q == COMMIT);
  assign miss_ready    = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_addr  = mem_req_valid ? addr_q : '0;
  assign wr_en         = commit && !err_q;
  assign tag_wr_en     = commit;
  assign tag_wr_valid  = commit && !err_q;
  assign fill_err      = commit && err_q;
  assign wr_line       = commit ? addr_q[LINE_W+1:2] : '0;
  assign wr_way        = commit ? way_q : '0;
  assign tag_wr_tag    = commit ? addr_q[ADDR_W-1:LINE_W+2] : '0;
  assign wr_data       = commit ? data_q : '0;
  assign crit_valid    = crit_vld_q;
  assign crit_data     = crit_vld_q ? crit_data_q : '0;

endmodule

// File: doc/ic_fill_ctrl.md
IC_FILL_CTRL -- requirements
Module: ic_fill_ctrl

Interface
REQ-001 Parameter ADDR_W, 16, instruction word-address width.
REQ-002 Parameter LINE_W, 8, line-index width; word offset is always 2 bits (4 x 16-bit words per line).
REQ-003 Parameter WAY_W, 2, way-select width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 miss_valid  in  1 / miss_ready  out  1  miss handshake; transfer when both high.
REQ-007 miss_addr  in  ADDR_W  word address of missing word; miss_way  in  WAY_W  victim way.
REQ-008 mem_req_valid  out  1 / mem_req_ready  in  1 / mem_req_addr  out  ADDR_W  memory line request.
REQ-009 mem_rsp_valid  in  1 / mem_rsp_data  in  16 / mem_rsp_err  in  1  response beats, no backpressure.
REQ-010 wr_en  out  1 / wr_line  out  LINE_W / wr_way  out  WAY_W / wr_data  out  64  data-RAM fill port, word w at bits [16w+15:16w].
REQ-011 tag_wr_en  out  1 / tag_wr_tag  out  ADDR_W-LINE_W-2 / tag_wr_valid  out  1  tag update, same line/way as wr_line/wr_way.
REQ-012 crit_valid  out  1 / crit_data  out  16  critical-word forward to fetch stage.
REQ-013 fill_err  out  1 / busy  out  1  error pulse / controller not idle.

Function
REQ-014 FSM states IDLE, REQ, RECV, COMMIT; one fill in flight at a time.
REQ-015 miss_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-016 IDLE: miss handshake captures addr, way, crit_word=miss_addr[1:0], clears beat count and error flag -> REQ next cycle.
REQ-017 REQ: mem_req_valid=1, mem_req_addr=miss_addr (not line-aligned; memory returns critical word first); held stable until mem_req_ready -> RECV.
REQ-018 RECV: each mem_rsp_valid beat k (0..3) SHALL be stored into word (crit_word+k) mod 4; count wraps only via state exit.
REQ-019 mem_rsp_valid outside RECV SHALL be ignored (no state or data change).
REQ-020 Beat 0 SHALL produce crit_valid=1 with crit_data=beat data exactly one cycle later, single-cycle pulse, unless mem_rsp_err on that beat.
REQ-021 Any beat with mem_rsp_err SHALL set a sticky error flag for the current fill.
REQ-022 After beat 3 accepted -> COMMIT; COMMIT lasts exactly one cycle, then IDLE.
REQ-023 COMMIT, no error: wr_en=1, tag_wr_en=1, tag_wr_valid=1, wr_line=addr[LINE_W+1:2], tag=addr[ADDR_W-1:LINE_W+2].
REQ-024 COMMIT, error: wr_en=0, tag_wr_en=1, tag_wr_valid=0, fill_err=1 one cycle.
REQ-025 wr_en, tag_wr_en, fill_err, crit_valid SHALL be zero in every cycle other than specified.
REQ-026 Latency, zero-wait memory: miss accepted cycle N, mem_req_valid N+1, beats N+2..N+5, COMMIT N+6, miss_ready N+7.
REQ-027 A miss presented during COMMIT SHALL NOT be accepted; accepted earliest cycle after COMMIT.

Reset
REQ-028 rst SHALL force IDLE, clear beat count and error flag, and drive all outputs to 0 except miss_ready=1.
REQ-029 rst in any state SHALL abort the fill with no wr_en/tag_wr_en/crit_valid pulse; beats arriving after rst are ignored.
REQ-030 Data/address capture registers need not be reset; outputs SHALL be gated by state.

Verification
REQ-031 Aligned fill: miss_addr=0x1234 (crit 0), beats A0,A1,A2,A3 -> crit_data=A0, wr_line=0x8D, wr_data=A3A2A1A0, tag=0x04, tag_wr_valid=1.
REQ-032 Wrapped fill: miss_addr=0x0007 (crit 3), beats B0..B3 -> word3=B0, word0=B1, word1=B2, word2=B3, crit_data=B0.
REQ-033 Backpressure: mem_req_ready low 5 cycles -> mem_req_valid/addr stable, no beats consumed, COMMIT 5 cycles later than REQ-026.
REQ-034 Error: mem_rsp_err on beat 2 -> wr_en never high, tag_wr_en=1 with tag_wr_valid=0, fill_err pulse in COMMIT.
REQ-035 Reset mid-RECV after beat 1 -> no wr_en/tag_wr_en, miss_ready=1 next cycle, trailing beats ignored, next fill correct.
REQ-036 Back-to-back misses held valid -> second accepted cycle after first COMMIT, stray beat in IDLE ignored.
